// File: rtl/pl_pkg.sv
// ---------------------------------------------------------------------------
// pl_pkg
// Shared definitions for the NewHope stage-pipeline scheduler.
//
// Contents:
//   schedState_t   - 2-bit encoding of the scheduler FSM states
//   DEF_NUM_STAGES - default number of pipeline stages sequenced
//   DEF_CNT_W      - default width of the epoch cycle counter
//   DEF_TIMEOUT    - default number of WAIT cycles before the watchdog fires
// ---------------------------------------------------------------------------
package pl_pkg;

   // One epoch walks LAUNCH -> WAIT (one or more cycles) -> ADVANCE.
   // IDLE is only visited when the whole pipeline is empty.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LAUNCH  = 2'd1,
      ST_WAIT    = 2'd2,
      ST_ADVANCE = 2'd3
   } schedState_t;

   localparam int DEF_NUM_STAGES = 8;
   localparam int DEF_CNT_W      = 16;
   localparam int DEF_TIMEOUT    = 16'hFFFF;

endpackage

// File: rtl/pl_scheduler.sv
// ---------------------------------------------------------------------------
// pl_scheduler
// Epoch-based scheduler for the pl_stage_0 .. pl_stage_N-1 pipeline. Every
// occupied slot is started together, the scheduler waits until each started
// stage has reported done, then shifts all jobs one slot deeper and admits a
// new job into slot 0. Epoch length is measured and a watchdog flags stages
// that never finish.
//
// Ports:
//   clk               in   clock
//   rst               in   synchronous active-low reset
//   en                in   global enable, low freezes FSM transitions
//   in_req            in   level request, a new job is ready for stage 0
//   in_ack            out  job accepted this cycle
//   stage_done        in   per-stage done (pulse or level)
//   stage_start       out  one-cycle start pulse to every occupied stage
//   slot_valid        out  occupancy of each stage
//   out_valid         out  one-cycle pulse, the job in the last stage finished
//   busy              out  any slot occupied or FSM not idle
//   error             out  sticky watchdog flag
//   last_epoch_cycles out  length in cycles of the last completed epoch
// ---------------------------------------------------------------------------
module pl_scheduler
   import pl_pkg::*;
#(
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  in_req,
   output logic                  in_ack,
   input  logic [NUM_STAGES-1:0] stage_done,
   output logic [NUM_STAGES-1:0] stage_start,
   output logic [NUM_STAGES-1:0] slot_valid,
   output logic                  out_valid,
   output logic                  busy,
   output logic                  error,
   output logic [CNT_W-1:0]      last_epoch_cycles
);

   schedState_t           r_state;
   logic [NUM_STAGES-1:0] r_slotValid;
   logic [NUM_STAGES-1:0] r_doneSeen;
   logic [CNT_W-1:0]      r_epochCnt;
   logic [CNT_W-1:0]      r_lastEpoch;
   logic                  r_error;

   logic [NUM_STAGES-1:0] w_doneMasked;
   logic                  w_allDone;
   logic [NUM_STAGES-1:0] w_nextSlots;
   logic [CNT_W-1:0]      w_cntInc;
   logic                  w_timeoutHit;

   // Done from an empty slot must never count towards completing an epoch,
   // so incoming dones are masked with occupancy before anything else.
   // The epoch is complete once the dones already collected plus the ones
   // arriving this cycle cover every occupied slot, which lets a WAIT cycle
   // that receives the final done move straight on to ADVANCE.
   assign w_doneMasked = stage_done & r_slotValid;
   assign w_allDone    = ((r_doneSeen | w_doneMasked) == r_slotValid);

   // Occupancy after the shift: every job moves one slot deeper, the job in
   // the last slot leaves, and slot 0 is filled if a request is waiting.
   assign w_nextSlots  = {r_slotValid[NUM_STAGES-2:0], in_req};

   // The epoch counter saturates at all-ones so a hung stage cannot wrap it
   // back to a small, plausible-looking epoch length. The same saturated
   // increment gives the epoch length that includes the ADVANCE cycle.
   assign w_cntInc     = (&r_epochCnt) ? r_epochCnt : (r_epochCnt + CNT_W'(1));
   assign w_timeoutHit = (r_epochCnt >= CNT_W'(TIMEOUT));

   // Handshake and start pulses are decoded straight from the registered
   // state so a stage sees start_stage in exactly the LAUNCH cycle. Dropping
   // en suppresses all three, which keeps a frozen scheduler from issuing
   // starts or accepting jobs it will not act on.
   assign in_ack      = en & in_req & ((r_state == ST_IDLE) | (r_state == ST_ADVANCE));
   assign stage_start = (en && (r_state == ST_LAUNCH)) ? r_slotValid : '0;
   assign out_valid   = en & (r_state == ST_ADVANCE) & r_slotValid[NUM_STAGES-1];

   // busy depends only on registers, so it is as clean as a flop output.
   assign busy              = (r_slotValid != '0) | (r_state != ST_IDLE);
   assign slot_valid        = r_slotValid;
   assign error             = r_error;
   assign last_epoch_cycles = r_lastEpoch;

   // Scheduler FSM. Done capture and the watchdog run whenever the FSM sits
   // in WAIT, even with en low, because the stages keep running while the
   // scheduler is frozen and their done pulses must not be lost. All state
   // transitions, counter updates and occupancy changes happen only with
   // en high. A hung stage leaves the FSM in WAIT with its jobs intact; the
   // error flag is the only reaction and it stays set until reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_slotValid <= '0;
         r_doneSeen  <= '0;
         r_epochCnt  <= '0;
         r_lastEpoch <= '0;
         r_error     <= 1'b0;
      end else begin
         if (r_state == ST_WAIT) begin
            r_doneSeen <= r_doneSeen | w_doneMasked;
            if (w_timeoutHit) begin
               r_error <= 1'b1;
            end
         end

         if (en) begin
            case (r_state)
               ST_IDLE: begin
                  if (in_req) begin
                     r_slotValid <= NUM_STAGES'(1);
                     r_state     <= ST_LAUNCH;
                  end
               end
               ST_LAUNCH: begin
                  r_doneSeen <= '0;
                  r_epochCnt <= CNT_W'(1);
                  r_state    <= ST_WAIT;
               end
               ST_WAIT: begin
                  r_epochCnt <= w_cntInc;
                  if (w_allDone) begin
                     r_state <= ST_ADVANCE;
                  end
               end
               ST_ADVANCE: begin
                  r_slotValid <= w_nextSlots;
                  r_lastEpoch <= w_cntInc;
                  r_state     <= (w_nextSlots != '0) ? ST_LAUNCH : ST_IDLE;
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pl_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pl_scheduler
// Directed self-checking bench for pl_scheduler with four stages and a short
// watchdog timeout. A behavioural stage model answers each start pulse with a
// done after a per-stage delay. Expected start patterns and out_valid cycles
// are queued by the directed steps and consumed by a monitor whenever the
// scheduler produces them.
// ---------------------------------------------------------------------------
module tb_pl_scheduler;

   localparam int N  = 4;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          in_req;
   logic          in_ack;
   logic [N-1:0]  stage_done;
   logic [N-1:0]  stage_start;
   logic [N-1:0]  slot_valid;
   logic          out_valid;
   logic          busy;
   logic          error;
   logic [CW-1:0] last_epoch_cycles;

   logic [N-1:0]  modelDone;
   logic [N-1:0]  forceDone;

   int checks  = 0;
   int errors  = 0;
   int cycleNo = 0;
   int t       = 0;

   int delayCfg [N];
   int doneCnt  [N];

   logic [N-1:0] expStartQ [$];
   int           expOutQ   [$];

   assign stage_done = modelDone | forceDone;

   pl_scheduler #(
      .NUM_STAGES (N),
      .CNT_W      (CW),
      .TIMEOUT    (8)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .en                (en),
      .in_req            (in_req),
      .in_ack            (in_ack),
      .stage_done        (stage_done),
      .stage_start       (stage_start),
      .slot_valid        (slot_valid),
      .out_valid         (out_valid),
      .busy              (busy),
      .error             (error),
      .last_epoch_cycles (last_epoch_cycles)
   );

   // 10 ns clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Single comparison point: every check in the bench goes through here so
   // the counters stay consistent.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next cycle: inputs change 1 ns after the rising edge and
   // the caller checks outputs 3 ns after the edge, well before the falling
   // edge where the stage model and the monitor act.
   task automatic applyStimulus(input logic rstN, input logic req, input logic enb, input logic [N-1:0] frc);
      @(posedge clk);
      #1;
      rst       = rstN;
      in_req    = req;
      en        = enb;
      forceDone = frc;
      cycleNo++;
      #2;
   endtask

   // Every output at its reset value.
   task automatic checkReset();
      checkOutput("rst_stage_start", 32'(stage_start), 32'h0);
      checkOutput("rst_in_ack", 32'(in_ack), 32'h0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
      checkOutput("rst_slot_valid", 32'(slot_valid), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_error", 32'(error), 32'h0);
      checkOutput("rst_last_epoch", 32'(last_epoch_cycles), 32'h0);
   endtask

   // Stage model: a start pulse seen on the falling edge of the LAUNCH cycle
   // loads a countdown; the done pulse is raised for one cycle when it
   // expires, so a delay of 1 returns done in the first WAIT cycle. A delay
   // of 0 models a hung stage that never answers.
   initial begin
      modelDone = '0;
      for (int i = 0; i < N; i++) begin
         doneCnt[i] = 0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            modelDone[i] = 1'b0;
            if (doneCnt[i] != 0) begin
               doneCnt[i]--;
               if (doneCnt[i] == 0) begin
                  modelDone[i] = 1'b1;
               end
            end
            if (stage_start[i] === 1'b1 && delayCfg[i] != 0) begin
               doneCnt[i] = delayCfg[i];
            end
            if (rst !== 1'b1) begin
               doneCnt[i]   = 0;
               modelDone[i] = 1'b0;
            end
         end
      end
   end

   // Scoreboard monitor: each start pulse must match the next queued
   // pattern, and each out_valid pulse must land on the next queued cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (|stage_start === 1'b1) begin
            if (expStartQ.size() == 0) begin
               checkOutput("start_extra", 32'(stage_start), 32'h0);
            end else begin
               checkOutput("start_pattern", 32'(stage_start), 32'(expStartQ.pop_front()));
            end
         end
         if (out_valid === 1'b1) begin
            if (expOutQ.size() == 0) begin
               checkOutput("out_extra", 32'(out_valid), 32'h0);
            end else begin
               checkOutput("out_cycle", 32'(cycleNo), 32'(expOutQ.pop_front()));
            end
         end
      end
   end

   // Directed sequence of scenarios.
   initial begin
      rst       = 1'b0;
      en        = 1'b0;
      in_req    = 1'b0;
      forceDone = '0;
      for (int i = 0; i < N; i++) begin
         delayCfg[i] = 1;
      end

      // Reset and one idle cycle with nothing requested.
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      checkReset();
      applyStimulus(1'b1, 1'b0, 1'b1, '0);
      checkOutput("idle_ack", 32'(in_ack), 32'h0);
      checkOutput("idle_busy", 32'(busy), 32'h0);

      // Single job through all four stages, every done one cycle after start.
      // Four 3-cycle epochs put out_valid 12 edges after the accept cycle.
      expStartQ.push_back(4'b0001);
      expStartQ.push_back(4'b0010);
      expStartQ.push_back(4'b0100);
      expStartQ.push_back(4'b1000);
      applyStimulus(1'b1, 1'b1, 1'b1, '0);
      t = cycleNo;
      checkOutput("A_ack", 32'(in_ack), 32'h1);
      expOutQ.push_back(t + 12);
      for (int k = 1; k <= 13; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, '0);
         if (k == 3) checkOutput("A_no_early_out", 32'(out_valid), 32'h0);
         if (k == 4) begin
            checkOutput("A_slot_after_adv", 32'(slot_valid), 32'h2);
            checkOutput("A_epoch_len", 32'(last_epoch_cycles), 32'd3);
         end
         if (k == 12) checkOutput("A_out_valid", 32'(out_valid), 32'h1);
         if (k == 13) begin
            checkOutput("A_idle_busy", 32'(busy), 32'h0);
            checkOutput("A_idle_slots", 32'(slot_valid), 32'h0);
            checkOutput("A_no_error", 32'(error), 32'h0);
         end
      end

      // in_req held for 16 cycles: one accept per epoch, pipeline fills to
      // 1111, then drains with out_valid every epoch from the 4th ADVANCE.
      expStartQ.push_back(4'b0001);
      expStartQ.push_back(4'b0011);
      expStartQ.push_back(4'b0111);
      expStartQ.push_back(4'b1111);
      expStartQ.push_back(4'b1111);
      expStartQ.push_back(4'b1111);
      expStartQ.push_back(4'b1110);
      expStartQ.push_back(4'b1100);
      expStartQ.push_back(4'b1000);
      for (int k = 0; k <= 28; k++) begin
         applyStimulus(1'b1, (k <= 15), 1'b1, '0);
         if (k == 0) begin
            t = cycleNo;
            for (int j = 4; j <= 9; j++) begin
               expOutQ.push_back(t + 3 * j);
            end
         end
         checkOutput("B_ack", 32'(in_ack), 32'((k <= 15) && (k % 3 == 0)));
         if (k == 9)  checkOutput("B_slots_0111", 32'(slot_valid), 32'h7);
         if (k == 10) checkOutput("B_slots_full", 32'(slot_valid), 32'hF);
         if (k == 27) checkOutput("B_slots_last", 32'(slot_valid), 32'h8);
         if (k == 28) checkOutput("B_drained", 32'(busy), 32'h0);
      end

      // Stage 2 answers 10 cycles after start: that epoch lasts 12 cycles
      // and no slot moves early. The 8-cycle watchdog also trips on the way.
      delayCfg[2] = 10;
      expStartQ.push_back(4'b0001);
      expStartQ.push_back(4'b0010);
      expStartQ.push_back(4'b0100);
      expStartQ.push_back(4'b1000);
      applyStimulus(1'b1, 1'b1, 1'b1, '0);
      t = cycleNo;
      checkOutput("C_ack", 32'(in_ack), 32'h1);
      expOutQ.push_back(t + 21);
      for (int k = 1; k <= 22; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, '0);
         if (k >= 8 && k <= 18) checkOutput("C_hold_slot", 32'(slot_valid), 32'h4);
         if (k == 15) checkOutput("C_error_not_yet", 32'(error), 32'h0);
         if (k == 16) checkOutput("C_error_set", 32'(error), 32'h1);
         if (k == 19) begin
            checkOutput("C_slot_after_slow", 32'(slot_valid), 32'h8);
            checkOutput("C_epoch_len", 32'(last_epoch_cycles), 32'd12);
         end
         if (k == 22) checkOutput("C_idle_busy", 32'(busy), 32'h0);
      end
      delayCfg[2] = 1;
      applyStimulus(1'b0, 1'b0, 1'b1, '0);
      applyStimulus(1'b1, 1'b0, 1'b1, '0);
      checkOutput("C_error_cleared", 32'(error), 32'h0);

      // Stale done[0] in LAUNCH and spurious done[3] with slot 3 empty; the
      // real done[0] arrives in the second WAIT cycle, giving a 4-cycle epoch.
      delayCfg[0] = 2;
      expStartQ.push_back(4'b0001);
      expStartQ.push_back(4'b0010);
      expStartQ.push_back(4'b0100);
      expStartQ.push_back(4'b1000);
      applyStimulus(1'b1, 1'b1, 1'b1, '0);
      t = cycleNo;
      checkOutput("D_ack", 32'(in_ack), 32'h1);
      expOutQ.push_back(t + 13);
      applyStimulus(1'b1, 1'b0, 1'b1, 4'b0001);
      applyStimulus(1'b1, 1'b0, 1'b1, 4'b1000);
      checkOutput("D_not_advanced", 32'(slot_valid), 32'h1);
      applyStimulus(1'b1, 1'b0, 1'b1, '0);
      checkOutput("D_still_slot0", 32'(slot_valid), 32'h1);
      for (int k = 4; k <= 14; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, '0);
         if (k == 4) checkOutput("D_adv_no_out", 32'(out_valid), 32'h0);
         if (k == 5) begin
            checkOutput("D_slot_after_adv", 32'(slot_valid), 32'h2);
            checkOutput("D_epoch_len", 32'(last_epoch_cycles), 32'd4);
         end
         if (k == 14) begin
            checkOutput("D_idle_busy", 32'(busy), 32'h0);
            checkOutput("D_last_epoch", 32'(last_epoch_cycles), 32'd3);
         end
      end
      delayCfg[0] = 1;

      // en low for one LAUNCH cycle (no start), then low for 5 WAIT cycles
      // while done[0] arrives; the capture survives and the epoch completes
      // on the first cycle en is back.
      expStartQ.push_back(4'b0001);
      expStartQ.push_back(4'b0010);
      expStartQ.push_back(4'b0100);
      expStartQ.push_back(4'b1000);
      applyStimulus(1'b1, 1'b1, 1'b1, '0);
      t = cycleNo;
      checkOutput("E_ack", 32'(in_ack), 32'h1);
      expOutQ.push_back(t + 18);
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      checkOutput("E_launch_frozen", 32'(stage_start), 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b1, '0);
      checkOutput("E_launch_start", 32'(stage_start), 32'h1);
      for (int k = 3; k <= 7; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, '0);
         checkOutput("E_frozen_start", 32'(stage_start), 32'h0);
         checkOutput("E_frozen_ack", 32'(in_ack), 32'h0);
         checkOutput("E_frozen_slot", 32'(slot_valid), 32'h1);
      end
      for (int k = 8; k <= 19; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, '0);
         if (k == 8) checkOutput("E_wait_resume", 32'(slot_valid), 32'h1);
         if (k == 10) begin
            checkOutput("E_slot_after_adv", 32'(slot_valid), 32'h2);
            checkOutput("E_epoch_len", 32'(last_epoch_cycles), 32'd3);
         end
         if (k == 19) checkOutput("E_idle_busy", 32'(busy), 32'h0);
      end

      // Hung stage 0 with TIMEOUT=8: error rises after 8 WAIT cycles, stays
      // set, the job is kept, and a mid-WAIT reset restores reset values.
      delayCfg[0] = 0;
      expStartQ.push_back(4'b0001);
      applyStimulus(1'b1, 1'b1, 1'b1, '0);
      checkOutput("F_ack", 32'(in_ack), 32'h1);
      for (int k = 1; k <= 14; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, '0);
         if (k == 9)  checkOutput("F_error_not_yet", 32'(error), 32'h0);
         if (k == 10) checkOutput("F_error_set", 32'(error), 32'h1);
         if (k == 14) begin
            checkOutput("F_error_sticky", 32'(error), 32'h1);
            checkOutput("F_job_kept", 32'(slot_valid), 32'h1);
            checkOutput("F_busy", 32'(busy), 32'h1);
         end
      end
      applyStimulus(1'b0, 1'b0, 1'b1, '0);
      checkOutput("F_reset_cycle_start", 32'(stage_start), 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b1, '0);
      checkReset();
      delayCfg[0] = 1;

      // Every queued start pattern and out_valid must have been consumed.
      applyStimulus(1'b1, 1'b0, 1'b1, '0);
      checkOutput("start_queue_left", 32'(expStartQ.size()), 32'h0);
      checkOutput("out_queue_left", 32'(expOutQ.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
